fp_exp_adjust_pipe: RTL and testbench
=====================================

Name: fp_exp_adjust_pipe

Overview:
Pipelined, parametrised exponent path for the floating-point multiplier. It adds the two biased operand exponents, removes the bias, and applies the normalisation correction derived from the leading-one position of the mantissa product. It detects overflow, underflow and zero results, and presents the result on a valid/ready stream. It sits between the mantissa multiplier/leading-one detector and the final pack/round stage.

Parameters:
EXP_W, 8, exponent field width in bits
MAN_W, 23, stored mantissa width; product width PROD_W = 2*(MAN_W+1)
BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1
POS_W, 6, leading-one position width; must satisfy 2^POS_W >= PROD_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input beat
exp_a  in  EXP_W  biased exponent of operand A
exp_b  in  EXP_W  biased exponent of operand B
lead_pos  in  POS_W  bit index of the product's leading one; 0 means the product is zero
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_exp  out  EXP_W  adjusted biased exponent
out_ovf  out  1  result overflowed; out_exp forced to all ones
out_unf  out  1  result underflowed; out_exp forced to 0
out_zero  out  1  zero result; out_exp is 0

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-high.
- On reset, all stage valids clear. out_valid=0, out_exp=0, out_ovf=0, out_unf=0, out_zero=0. in_ready=1 from the first clock after rst deasserts.
- Reset mid-operation discards all in-flight beats; no partial result is emitted.
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. A beat is accepted when in_valid && in_ready.
- Held outputs: out_valid, once high, stays high and out_* stay stable until out_ready=1.
- Pipeline: two register stages (S1, S2). Latency is 2 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- S1: z1 = (exp_a==0) || (exp_b==0) || (lead_pos==0). Zero/denormal operands are flushed to zero.
- S1 arithmetic: s1 = exp_a + exp_b - BIAS, computed signed in EXP_W+3 bits with no wrap; lead_pos is registered alongside.
- S2 normalisation: e = s1 + lead_pos - (PROD_W-2).
  - PROD_W=48: lead 47 gives +1, lead 46 gives 0, lead 45 gives -1, and so on.
- S2 classification, in priority order:
  - z1: out_zero=1, out_exp=0, out_ovf=0, out_unf=0.
  - e >= 2^EXP_W-1: out_ovf=1, out_exp=all ones.
  - e <= 0: out_unf=1, out_exp=0.
  - Otherwise: out_exp=e[EXP_W-1:0], all flags 0.
- Exactly one of out_ovf, out_unf, out_zero is 1, or none of them.
- Stage advance rules:
  - S2 loads when S2 is empty or being consumed (out_ready=1).
  - S1 loads when S1 is empty or S1 moves to S2 in the same cycle.
  - in_ready = !S1_valid || S2_load. This is combinational from out_ready; no extra bubble is allowed.
- Full condition: both stages hold beats and out_ready=0 gives in_ready=0. This holds at most 2 beats; no beat is lost or duplicated.
- Simultaneous accept and emit with a full pipe is legal when out_ready=1; S2 drains, S1 shifts and a new beat enters in the same cycle.
- Ordering: strict FIFO; no reordering.
- Inputs are sampled only on an accepted beat.

Test Plan:
1. Nominal single-precision cases, defaults, out_ready=1:
   - exp_a=127, exp_b=127, lead_pos=47 -> 2 cycles later out_exp=128, flags 0.
   - exp_a=127, exp_b=127, lead_pos=46 -> out_exp=127.
   - exp_a=127, exp_b=127, lead_pos=45 -> out_exp=126.
2. Overflow: exp_a=254, exp_b=254, lead_pos=47 -> out_ovf=1, out_exp=255. Boundary: exp_a=200, exp_b=181, lead_pos=46 -> e=254, out_exp=254, out_ovf=0.
3. Underflow and zero:
   - exp_a=1, exp_b=1, lead_pos=46 -> out_unf=1, out_exp=0.
   - exp_a=64, exp_b=64, lead_pos=46 -> e=1, out_exp=1.
   - exp_a=0, exp_b=200, lead_pos=47 -> out_zero=1, out_exp=0, out_unf=0.
   - lead_pos=0 with nonzero exponents -> out_zero=1.
4. Backpressure: stream 4 beats (exp_a=100..103, exp_b=127, lead_pos=46) with out_ready=0 -> in_ready drops after 2 accepted. Release out_ready -> outputs 100,101,102,103 in order, one per cycle, stable while stalled.
5. Full-rate streaming: 16 random beats with in_valid=out_ready=1 -> one result per cycle after a 2-cycle latency, matching a reference model.
6. Reset mid-stream: assert rst while 2 beats are in flight -> outputs and flags 0 immediately (async). After release, in_ready=1 and no stale result appears; the next beat (127,127,47) yields 128.

Source files
------------

// File: rtl/fp_exp_adjust_pipe.sv
// Two-stage exponent path for the FP multiplier: biased add, bias removal,
// leading-one normalisation and overflow/underflow/zero classification.
module fp_exp_adjust_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127,
  parameter int POS_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [POS_W-1:0] lead_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_zero
);

  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int SW     = EXP_W + 3;
  localparam int EW     = ((SW > POS_W + 1) ? SW : POS_W + 1) + 1;

  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] NORM  = EW'(PROD_W - 2);
  localparam logic signed [SW-1:0] BIASS = SW'(BIAS);

  logic                    s1_valid;
  logic                    s1_zero;
  logic signed [SW-1:0]    s1_sum;
  logic        [POS_W-1:0] s1_lead;

  logic                    s2_load;
  logic signed [SW-1:0]    a_ext, b_ext, sum_next;
  logic                    zero_next;
  logic signed [EW-1:0]    e;
  logic signed [EW-1:0]    lead_ext;
  logic        [EXP_W-1:0] e_exp;
  logic                    e_ovf, e_unf;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_comb begin
    a_ext     = SW'(exp_a);
    b_ext     = SW'(exp_b);
    sum_next  = a_ext + b_ext - BIASS;
    zero_next = (exp_a == '0) || (exp_b == '0) || (lead_pos == '0);
  end

  // Sign-extend the stage-1 sum before normalising so negative results compare correctly.
  always_comb begin
    lead_ext = EW'(s1_lead);
    e        = EW'(s1_sum) + lead_ext - NORM;
    e_exp    = e[EXP_W-1:0];
    e_ovf    = 1'b0;
    e_unf    = 1'b0;
    if (e >= EMAX) begin
      e_ovf = 1'b1;
      e_exp = '1;
    end else if (e[EW-1] || (e == '0)) begin
      e_unf = 1'b1;
      e_exp = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sum    <= '0;
      s1_lead   <= '0;
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          if (s1_zero) begin
            out_exp  <= '0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
            out_zero <= 1'b1;
          end else begin
            out_exp  <= e_exp;
            out_ovf  <= e_ovf;
            out_unf  <= e_unf;
            out_zero <= 1'b0;
          end
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum  <= sum_next;
          s1_zero <= zero_next;
          s1_lead <= lead_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_exp_adjust_pipe.sv
// Scoreboard bench for fp_exp_adjust_pipe: driver pushes model results, a
// negedge monitor pops and compares on every output transfer.
module tb_fp_exp_adjust_pipe;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int POS_W  = 6;
  localparam int PROD_W = 2 * (MAN_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a = '0;
  logic [EXP_W-1:0] exp_b = '0;
  logic [POS_W-1:0] lead_pos = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [EXP_W-1:0] out_exp;
  logic             out_ovf, out_unf, out_zero;

  fp_exp_adjust_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .lead_pos(lead_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    bit ovf;
    bit unf;
    bit zero;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   chk_lat = 1'b1;

  bit         held = 1'b0;
  logic [7:0] h_exp;
  logic [2:0] h_fl;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int a, input int b, input int l);
    exp_t r;
    int   v;
    r.ovf = 0; r.unf = 0; r.zero = 0; r.acc = 0;
    v = (a - BIAS) + b + (l - (PROD_W - 2));
    if (a == 0 || b == 0 || l == 0) begin
      r.zero = 1; r.e = 0;
    end else if (v >= (1 << EXP_W) - 1) begin
      r.ovf = 1; r.e = (1 << EXP_W) - 1;
    end else if (v <= 0) begin
      r.unf = 1; r.e = 0;
    end else begin
      r.e = v;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (held) begin
        check("hold_exp", int'(out_exp), int'(h_exp));
        check("hold_flags", int'({out_ovf, out_unf, out_zero}), int'(h_fl));
      end
      if (out_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("out_exp", int'(out_exp), x.e);
          check("out_flags", int'({out_ovf, out_unf, out_zero}), int'({x.ovf, x.unf, x.zero}));
          if (chk_lat) check("latency", cyc - x.acc, 2);
        end
      end else begin
        held  = 1'b1;
        h_exp = out_exp;
        h_fl  = {out_ovf, out_unf, out_zero};
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input int a, input int b, input int l);
    int   n;
    bit   ok;
    exp_t x;
    n  = 0;
    ok = 0;
    in_valid = 1'b1;
    exp_a    = a[EXP_W-1:0];
    exp_b    = b[EXP_W-1:0];
    lead_pos = l[POS_W-1:0];
    while (!ok && n < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else n++;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      x     = model(a, b, l);
      x.acc = cyc;
      sb.push_back(x);
      acc_cnt++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_a    = EXP_W'($urandom);
      exp_b    = EXP_W'($urandom);
      lead_pos = POS_W'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_exp", int'(out_exp), 0);
    check("rst_flags", int'({out_ovf, out_unf, out_zero}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(in_ready), 1);

    // Directed nominal, overflow, underflow and zero cases at full rate
    @(posedge clk); #1;
    send(127, 127, 47);
    send(127, 127, 46);
    send(127, 127, 45);
    send(254, 254, 47);
    send(200, 181, 46);
    send(1, 1, 46);
    send(64, 64, 46);
    send(0, 200, 47);
    send(150, 90, 0);
    send(255, 255, 47);
    drain();

    // Backpressure: only two beats fit while out_ready is low
    out_ready = 1'b0;
    chk_lat   = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(100 + i, 127, 46);
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_accepted", acc_cnt, 2);
        check("bp_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // Random full-rate stream
    for (int i = 0; i < 16; i++)
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 47)));
    drain();

    // Random stream under random backpressure
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), int'($urandom_range(30, 47)));
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // Reset with two beats in flight
    send(127, 127, 47);
    send(130, 127, 46);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_exp", int'(out_exp), 0);
    check("midrst_flags", int'({out_ovf, out_unf, out_zero}), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_stale", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(127, 127, 47);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
